// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver, majority-vote sampling, valid/ready holding register.
// Optional UART_RX_BREAK_DETECT_EN adds break_det and keeps break frames out of the holding register.
module uart_rx_os #(
  parameter int N           = 8,
  parameter int M           = 1,
  parameter int PARITY_MODE = 0,
  parameter int OVERSAMPLE  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         valid,
  input  logic         ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic         break_det,
`endif
  output logic         busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(N);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          st_q, st_d;
  logic [1:0]    smp_q, smp_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          pe_q, pe_d, fe_q, fe_d;
  logic [N-1:0]  data_q;
  logic          valid_q, perr_q, ferr_q, ovr_q;
  logic          rxs, maj, dec, bit_end, last_stop, done;
`ifdef UART_RX_BREAK_DETECT_EN
  logic          pbit_q, pbit_d, fs0_q, fs0_d, wait_q, wait_d, brk, brk_q;
`endif

  assign rxs       = sync_q[1];
  assign dec       = tick && s_cnt_q == S_DEC;
  assign bit_end   = tick && s_cnt_q == S_END;
  assign last_stop = st_q == 1'(M - 1);
  // the third vote is the live synchronised sample at the decision tick
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      s_cnt_q <= '0;
      idx_q   <= '0;
      st_q    <= 1'b0;
      smp_q   <= '0;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      pbit_q  <= 1'b0;
      fs0_q   <= 1'b0;
      wait_q  <= 1'b0;
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      s_cnt_q <= s_cnt_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
      pbit_q  <= pbit_d;
      fs0_q   <= fs0_d;
      wait_q  <= wait_d;
      brk_q   <= brk;
`endif
      if (done) begin
        data_q  <= sh_q;
        perr_q  <= pe_q;
        ferr_q  <= fe_q | ~maj;
        ovr_q   <= valid_q & ~ready;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = tick ? (s_cnt_q == S_END ? '0 : s_cnt_q + 1'b1) : s_cnt_q;
    idx_d   = idx_q;
    st_d    = st_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    done    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    pbit_d  = pbit_q;
    fs0_d   = fs0_q;
    wait_d  = wait_q;
    brk     = 1'b0;
`endif
    if (tick && s_cnt_q == S_LO) smp_d[0] = rxs;
    if (tick && s_cnt_q == S_MID) smp_d[1] = rxs;
    case (state_q)
      IDLE: begin
        s_cnt_d = '0;
        idx_d   = '0;
        st_d    = 1'b0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        wait_d  = 1'b0;
`endif
        if (tick && !rxs) state_d = START;
      end
      START: begin
        if (dec && maj) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (dec) sh_d = {maj, sh_q[N-1:1]};
        if (bit_end) begin
          if (idx_q == IW'(N - 1)) state_d = PARITY_MODE != 0 ? PARITY : STOP;
          else idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (dec) pe_d = maj ^ (^sh_q) ^ (PARITY_MODE == 2);
`ifdef UART_RX_BREAK_DETECT_EN
        if (dec) pbit_d = maj;
`endif
        if (bit_end) state_d = STOP;
      end
      STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
        if (wait_q) begin
          if (tick && rxs) state_d = IDLE;
        end else
`endif
        begin
          if (dec && !maj) fe_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          if (dec && !st_q) fs0_d = !maj;
`endif
          // last stop bit finishes mid-bit so a back-to-back start edge is not missed
          if (dec && last_stop) begin
            state_d = IDLE;
            done    = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (sh_q == '0 && (PARITY_MODE == 0 || !pbit_q) && (st_q ? fs0_q : !maj)) begin
              brk     = 1'b1;
              done    = 1'b0;
              state_d = STOP;
              wait_d  = 1'b1;
            end
`endif
          end
          if (bit_end && !last_stop) st_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = state_q != IDLE;
    data_out   = data_q;
    valid      = valid_q;
    parity_err = perr_q;
    frame_err  = ferr_q;
    overrun    = ovr_q;
`ifdef UART_RX_BREAK_DETECT_EN
    break_det  = brk_q;
`endif
  end
endmodule
